// File: rtl/adc_pattern_gen.sv
// Synthetic LTC2387-style sample source: programmable rate, leading discarded
// conversions, selectable data patterns and single-bit error injection.
module adc_pattern_gen #(
  parameter int unsigned          ADC_BITS     = 18,
  parameter logic [ADC_BITS-1:0]  PATTERN      = 18'b11_0011_0000_1111_1100,
  parameter int unsigned          DIV_WIDTH    = 16,
  parameter int unsigned          SKIP_SAMPLES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [1:0]           mode,
  input  logic [DIV_WIDTH-1:0] rate_div,
  input  logic [31:0]          num_samples,
  input  logic                 inject_err,
  output logic                 adc_valid,
  output logic [ADC_BITS-1:0]  adc_data,
  output logic                 busy,
  output logic                 done,
  output logic [31:0]          num_sent,
  output logic [31:0]          num_err
);

  localparam int unsigned SKIP_W = (SKIP_SAMPLES > 1) ? $clog2(SKIP_SAMPLES) : 1;
  localparam logic [SKIP_W-1:0] SKIP_LAST =
    SKIP_W'((SKIP_SAMPLES == 0) ? 0 : SKIP_SAMPLES - 1);

  typedef enum logic [1:0] {IDLE, SKIP, RUN, DONE} state_t;

  state_t               state, next_state;
  logic                 started;
  logic [1:0]           mode_q;
  logic [DIV_WIDTH-1:0] rate_q;
  logic [DIV_WIDTH-1:0] div_cnt;
  logic [31:0]          nsamp_q;
  logic [SKIP_W-1:0]    skip_cnt;
  logic [ADC_BITS-1:0]  seq;
  logic [ADC_BITS-1:0]  seq_next;
  logic                 err_pending;

  logic                 rise;
  logic                 tick;
  logic                 load;
  logic                 issue_skip;
  logic                 issue_valid;
  logic [31:0]          sent_inc;
  logic [31:0]          err_inc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // Next state and conversion strobes; an abort (start low) wins over a conversion.
  always_comb begin
    next_state  = state;
    load        = 1'b0;
    issue_skip  = 1'b0;
    issue_valid = 1'b0;
    rise        = start & ~started;
    tick        = (div_cnt == rate_q);
    sent_inc    = (num_sent == 32'hFFFF_FFFF) ? num_sent : num_sent + 32'd1;
    err_inc     = (num_err  == 32'hFFFF_FFFF) ? num_err  : num_err  + 32'd1;
    case (state)
      IDLE: begin
        if (rise) begin
          load       = 1'b1;
          next_state = (SKIP_SAMPLES == 0) ? RUN : SKIP;
        end
      end
      SKIP: begin
        if (!start) begin
          next_state = IDLE;
        end else if (tick) begin
          issue_skip = 1'b1;
          if (skip_cnt == SKIP_LAST) next_state = RUN;
        end
      end
      RUN: begin
        if (!start) begin
          next_state = IDLE;
        end else if (tick) begin
          issue_valid = 1'b1;
          if ((nsamp_q != 32'd0) && (sent_inc == nsamp_q)) next_state = DONE;
        end
      end
      DONE: begin
        if (!start) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Data sequence advance per mode; only valid samples move it.
  always_comb begin
    seq_next = seq;
    case (mode_q)
      2'd0:    seq_next = seq;
      2'd1:    seq_next = ~seq;
      2'd2:    seq_next = seq + ADC_BITS'(1);
      default: seq_next = {seq[ADC_BITS-2:0], seq[ADC_BITS-1]};
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      started     <= 1'b1;
      adc_valid   <= 1'b0;
      adc_data    <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      num_sent    <= 32'd0;
      num_err     <= 32'd0;
      mode_q      <= 2'd0;
      rate_q      <= '0;
      nsamp_q     <= 32'd0;
      div_cnt     <= '0;
      skip_cnt    <= '0;
      seq         <= '0;
      err_pending <= 1'b0;
    end else begin
      started   <= start;
      adc_valid <= issue_valid;
      busy      <= (state == SKIP) || (state == RUN);
      done      <= (state == DONE);

      if (load) begin
        mode_q   <= mode;
        rate_q   <= rate_div;
        nsamp_q  <= num_samples;
        num_sent <= 32'd0;
        num_err  <= 32'd0;
        div_cnt  <= '0;
        skip_cnt <= '0;
        seq      <= (mode == 2'd2) ? '0 : PATTERN;
      end else if (start && ((state == SKIP) || (state == RUN))) begin
        div_cnt <= tick ? '0 : div_cnt + DIV_WIDTH'(1);
      end

      if (issue_skip) begin
        skip_cnt <= skip_cnt + SKIP_W'(1);
        adc_data <= ~PATTERN;
      end

      if (issue_valid) begin
        adc_data <= seq ^ ADC_BITS'(err_pending);
        num_sent <= sent_inc;
        seq      <= seq_next;
        if (err_pending) num_err <= err_inc;
      end

      // A pulse coinciding with a valid sample is kept for the following one.
      err_pending <= load ? 1'b0 : (inject_err | (err_pending & ~issue_valid));
    end
  end

endmodule

// File: tb/tb_adc_pattern_gen.sv
// Directed bench for adc_pattern_gen: vector table of runs plus hand-written
// sequences for error injection, abort/restart and asynchronous reset.
module tb_adc_pattern_gen;

  localparam logic [17:0] PAT  = 18'h330FC;
  localparam logic [17:0] NPAT = 18'h0CF03;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  mode;
  logic [15:0] rate_div;
  logic [31:0] num_samples;
  logic        inject_err;
  logic        adc_valid;
  logic [17:0] adc_data;
  logic        busy;
  logic        done;
  logic [31:0] num_sent;
  logic [31:0] num_err;

  int n_cmp  = 0;
  int n_fail = 0;

  adc_pattern_gen dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .mode        (mode),
    .rate_div    (rate_div),
    .num_samples (num_samples),
    .inject_err  (inject_err),
    .adc_valid   (adc_valid),
    .adc_data    (adc_data),
    .busy        (busy),
    .done        (done),
    .num_sent    (num_sent),
    .num_err     (num_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]       mode;
    logic [15:0]      rate;
    logic [31:0]      nsamp;
    logic [3:0][17:0] exp_w;
    logic [17:0]      exp_last;
  } vec_t;

  vec_t vecs [5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Start edge is seen in cycle T; loop cycle c is T+c, sampled at the falling edge.
  task automatic run_vec(input vec_t v);
    int   p;
    int   clast;
    int   n;
    int   k;
    int   j;
    logic ev;
    @(negedge clk);
    mode        = v.mode;
    rate_div    = v.rate;
    num_samples = v.nsamp;
    start       = 1'b1;
    p     = int'(v.rate) + 1;
    n     = int'(v.nsamp);
    clast = 1 + (n + 2) * p;
    for (int c = 1; c <= clast + 1; c++) begin
      @(negedge clk);
      ev = 1'b0;
      if (c > 1 && ((c - 1) % p) == 0) begin
        k = (c - 1) / p - 1;
        if (k < 2) begin
          chk("skip_data", 32'(adc_data), 32'(NPAT));
        end else begin
          j = k - 2;
          if (j < n) ev = 1'b1;
          if (j < 4 && j < n) chk("run_data", 32'(adc_data), 32'(v.exp_w[j]));
          if (j == n - 1)     chk("last_data", 32'(adc_data), 32'(v.exp_last));
        end
      end
      chk("valid", 32'(adc_valid), 32'(ev));
      if (c == 2) chk("busy_run", 32'(busy), 32'd1);
      if (c == clast + 1) begin
        chk("done", 32'(done), 32'd1);
        chk("num_sent", num_sent, v.nsamp);
        chk("num_err", num_err, 32'd0);
      end
    end
    repeat (3) begin
      @(negedge clk);
      chk("hold_done", 32'(done), 32'd1);
      chk("hold_valid", 32'(adc_valid), 32'd0);
    end
    start = 1'b0;
    repeat (2) @(negedge clk);
    chk("idle_done", 32'(done), 32'd0);
    chk("idle_busy", 32'(busy), 32'd0);
  endtask

  task automatic err_seq();
    int k;
    int j;
    int n_mis;
    n_mis = 0;
    @(negedge clk);
    mode = 2'd0; rate_div = 16'd2; num_samples = 32'd0; start = 1'b1;
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      if (c > 1 && ((c - 1) % 3) == 0) begin
        k = (c - 1) / 3 - 1;
        if (k >= 2) begin
          j = k - 2;
          chk("err_valid", 32'(adc_valid), 32'd1);
          chk("err_data", 32'(adc_data), (j == 5) ? 32'(PAT ^ 18'd1) : 32'(PAT));
          if (adc_data != PAT) n_mis++;
        end
      end
      inject_err = (c == 21) || (c == 23);
    end
    inject_err = 1'b0;
    chk("err_count", num_err, 32'd1);
    chk("err_checker", 32'(n_mis), 32'd1);
    start = 1'b0;
    repeat (2) @(negedge clk);
    chk("err_idle", 32'(busy), 32'd0);
  endtask

  task automatic abort_seq();
    @(negedge clk);
    mode = 2'd0; rate_div = 16'd0; num_samples = 32'd0; start = 1'b1;
    repeat (10) @(negedge clk);
    chk("abort_pre_valid", 32'(adc_valid), 32'd1);
    chk("abort_pre_sent", num_sent, 32'd7);
    start = 1'b0;
    @(negedge clk);
    chk("abort_valid", 32'(adc_valid), 32'd0);
    chk("abort_sent", num_sent, 32'd7);
    @(negedge clk);
    chk("abort_hold", num_sent, 32'd7);
    chk("abort_busy", 32'(busy), 32'd0);
    start = 1'b1;
    @(negedge clk);
    chk("restart_clear", num_sent, 32'd0);
    for (int c = 2; c <= 3; c++) begin
      @(negedge clk);
      chk("restart_skip_v", 32'(adc_valid), 32'd0);
      chk("restart_skip_d", 32'(adc_data), 32'(NPAT));
    end
    @(negedge clk);
    chk("restart_valid", 32'(adc_valid), 32'd1);
    chk("restart_data", 32'(adc_data), 32'(PAT));
    chk("restart_sent", num_sent, 32'd1);
    start = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic reset_seq();
    @(negedge clk);
    mode = 2'd2; rate_div = 16'd0; num_samples = 32'd0; start = 1'b1;
    repeat (6) @(negedge clk);
    chk("pre_rst_data", 32'(adc_data), 32'd2);
    #2 rst = 1'b1;
    #1;
    chk("rst_valid", 32'(adc_valid), 32'd0);
    chk("rst_data", 32'(adc_data), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_sent", num_sent, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (5) begin
      @(negedge clk);
      chk("no_restart_busy", 32'(busy), 32'd0);
      chk("no_restart_valid", 32'(adc_valid), 32'd0);
    end
    start = 1'b0;
    @(negedge clk);
    start = 1'b1;
    repeat (4) @(negedge clk);
    chk("retoggle_valid", 32'(adc_valid), 32'd1);
    chk("retoggle_data", 32'(adc_data), 32'd0);
    start = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{mode: 2'd0, rate: 16'd0, nsamp: 32'd10,
                exp_w: {PAT, PAT, PAT, PAT}, exp_last: PAT};
    vecs[1] = '{mode: 2'd2, rate: 16'd3, nsamp: 32'd5,
                exp_w: {18'd3, 18'd2, 18'd1, 18'd0}, exp_last: 18'd4};
    vecs[2] = '{mode: 2'd1, rate: 16'd0, nsamp: 32'd4,
                exp_w: {NPAT, PAT, NPAT, PAT}, exp_last: NPAT};
    vecs[3] = '{mode: 2'd3, rate: 16'd0, nsamp: 32'd19,
                exp_w: {18'h187E6, 18'h0C3F3, 18'h261F9, PAT}, exp_last: PAT};
    vecs[4] = '{mode: 2'd2, rate: 16'd1, nsamp: 32'd3,
                exp_w: {18'd0, 18'd2, 18'd1, 18'd0}, exp_last: 18'd2};

    rst = 1'b1; start = 1'b0; mode = 2'd0; rate_div = 16'd0;
    num_samples = 32'd0; inject_err = 1'b0;
    @(negedge clk);
    chk("reset_valid", 32'(adc_valid), 32'd0);
    chk("reset_data", 32'(adc_data), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_sent", num_sent, 32'd0);
    chk("reset_err", num_err, 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 5; i++) run_vec(vecs[i]);
    err_seq();
    abort_seq();
    reset_seq();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/adc_pattern_gen.md
Name: adc_pattern_gen

Overview:
- Synthetic source for the ADC capture path. Emulates the LTC2387 sample stream so the capture and checker logic can be exercised without real hardware.
- Drives adc_valid/adc_data at a programmable conversion rate.
- The first SKIP_SAMPLES conversions after start are issued with adc_valid low, mirroring the datasheet rule that the first two conversions are discarded.
- Data content is selectable: fixed pattern, alternating, ramp or rotating. Supports single-bit error injection.

Parameters:
ADC_BITS, 18, sample width
PATTERN, 18'b11_0011_0000_1111_1100, reference word, ADC_BITS wide
DIV_WIDTH, 16, width of rate_div
SKIP_SAMPLES, 2, conversions discarded (valid low) after each start; 0 allowed

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
start  in  1  level; rising edge begins a run, low aborts/ends a run
mode  in  2  0 fixed, 1 alternating, 2 ramp, 3 rotate-left; latched at start
rate_div  in  DIV_WIDTH  conversion period = rate_div+1 clk cycles; latched at start
num_samples  in  32  valid samples per run; 0 = continuous; latched at start
inject_err  in  1  pulse; flips bit 0 of the next valid sample
adc_valid  out  1  one-cycle strobe per emitted valid sample
adc_data  out  ADC_BITS  sample word
busy  out  1  high in SKIP or RUN
done  out  1  high in DONE
num_sent  out  32  valid samples emitted this run, saturating
num_err  out  32  errors injected this run, saturating

Behaviour:
- Reset values: adc_valid=0, adc_data=0, busy=0, done=0, num_sent=0, num_err=0, state IDLE, div_cnt=0, err_pending=0. All outputs are registered.
- start is registered as started. A rising edge means start=1 and started=0.
- States: IDLE, SKIP, RUN, DONE.
  - IDLE: on a rising edge, latch mode/rate_div/num_samples, clear num_sent, num_err, div_cnt, skip count and sequence state. Go to SKIP, or to RUN if SKIP_SAMPLES=0.
  - SKIP/RUN: div_cnt increments each cycle. When div_cnt==rate_div, a conversion is issued and div_cnt returns to 0.
  - Timing: if the rising edge is seen in cycle T, conversion k appears on the outputs in cycle T+1+(k+1)*(rate_div+1). With rate_div=0, the output rate is one conversion per cycle.
  - SKIP: each conversion drives adc_data=~PATTERN with adc_valid=0. After SKIP_SAMPLES conversions, go to RUN. The skipped conversions do not advance the data sequence.
  - RUN: each conversion drives adc_valid=1 for exactly one cycle, with data per mode:
    - mode 0: PATTERN on every sample.
    - mode 1: PATTERN, ~PATTERN, PATTERN, … (first valid sample is PATTERN).
    - mode 2: 0, 1, 2, …; wraps 2^ADC_BITS-1 → 0.
    - mode 3: PATTERN, then rotated left by one bit per sample; period ADC_BITS.
  - RUN exit: when num_samples≠0 and the emitted sample makes num_sent==num_samples, go to DONE at the same edge.
  - DONE: done=1, adc_valid=0, counters hold for readback. Go to IDLE when start goes low.
- start low in SKIP or RUN aborts: next state IDLE, adc_valid=0 on the following cycle, counters hold.
- Leaving IDLE needs a new rising edge. start held high after DONE does not restart.
- Error injection:
  - An inject_err pulse sets err_pending, accepted in any state. Multiple pulses before the next valid sample collapse into one.
  - The next RUN valid sample has adc_data[0] inverted, num_err increments, and err_pending clears. The sequence state is unaffected, so the following sample is clean.
  - If inject_err arrives in the same cycle a valid sample is issued, it applies to the following sample.
  - A new run start clears err_pending.
- adc_valid=0 outside RUN conversions. adc_data holds its last value between strobes.
- num_sent and num_err saturate at 32'hFFFF_FFFF.
- Asynchronous reset mid-run forces IDLE and the reset values immediately.

Test Plan:
- Basic run: mode 0, rate_div=0, num_samples=10, start rise seen at cycle T -> adc_valid low at T+2 and T+3, then valid high T+4..T+13 with data=PATTERN. done=1 from T+14; num_sent=10. A checker fed this stream reports 10 matches, 0 mismatches.
- Slow rate: mode 2, rate_div=3, num_samples=5 -> valid strobes exactly 4 cycles apart, data 0,1,2,3,4; adc_valid never high for two consecutive cycles.
- Alternating and rotate: mode 1, num_samples=4 -> PATTERN, ~PATTERN, PATTERN, ~PATTERN. mode 3, num_samples=19 -> sample 18 equals PATTERN again.
- Error injection: mode 0, continuous, two inject_err pulses before sample 5 -> exactly one sample with data=PATTERN^1; num_err=1; neighbouring samples are PATTERN. A checker reports exactly 1 mismatch.
- Abort and restart: start drops mid-run after 7 samples -> adc_valid low from the next cycle, num_sent holds 7. A new start rise clears num_sent to 0 and repeats the skip phase.
- Reset mid-run: rst asserted asynchronously during RUN -> all outputs 0 before the next clk edge. With start held high after rst release, no run begins until start toggles low then high.
